// File: rtl/bist_sequencer_if.sv
// Datapath-side bundle between the BIST sequencer (master) and the LFSR/core/signature analyzer (slave).
// Names are kept from the sequencer's point of view, so _o signals are driven by the master.
interface bist_sequencer_if #(
  parameter int DATA_W = 24
) ();
  logic              seed_load_o;
  logic [DATA_W-1:0] seed_o;
  logic              lfsr_en_o;
  logic              px_req_o;
  logic              px_done_i;
  logic              sa_done_i;
  logic [DATA_W-1:0] sa_sig_i;

  modport master (
    output seed_load_o, seed_o, lfsr_en_o, px_req_o,
    input  px_done_i, sa_done_i, sa_sig_i
  );

  modport slave (
    input  seed_load_o, seed_o, lfsr_en_o, px_req_o,
    output px_done_i, sa_done_i, sa_sig_i
  );
endinterface

// File: rtl/bist_sequencer.sv
// BIST sequencer: seed load, pixel issue/return, signature check; ~6 cycles start-to-done minimum.
// Requests stall while MAX_OUTSTANDING pixels are in flight; BIST_SIG_CAPTURE_EN adds sig_o/mismatch_o.
module bist_sequencer #(
  parameter int DATA_W          = 24,
  parameter int COUNT_W         = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_W       = 10
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [COUNT_W-1:0] num_px_i,
  input  logic [DATA_W-1:0]  seed_i,
  input  logic [DATA_W-1:0]  golden_i,
  bist_sequencer_if.master   dp,
  output logic               busy_o,
  output logic               done_o,
  output logic               pass_o,
  output logic               fail_o,
  output logic               timeout_o,
  output logic [COUNT_W-1:0] px_count_o
`ifdef BIST_SIG_CAPTURE_EN
  ,
  output logic [DATA_W-1:0]  sig_o,
  output logic [DATA_W-1:0]  mismatch_o
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    SEED,
    RUN,
    DRAIN,
    SIGN,
    CHECK,
    DONE
  } state_e;

  localparam logic [COUNT_W-1:0] MaxOut = COUNT_W'(MAX_OUTSTANDING);

  state_e               state_q, state_d;
  logic                 start_q;
  logic [COUNT_W-1:0]   num_px_q, num_px_d;
  logic [DATA_W-1:0]    seed_q, seed_d;
  logic [DATA_W-1:0]    golden_q, golden_d;
  logic [COUNT_W-1:0]   issued_q, issued_d;
  logic [COUNT_W-1:0]   returned_q, returned_d;
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
  logic                 pass_q, pass_d;
  logic                 fail_q, fail_d;
  logic                 timeout_q, timeout_d;
`ifdef BIST_SIG_CAPTURE_EN
  logic [DATA_W-1:0]    sig_q, sig_d;
  logic [DATA_W-1:0]    mism_q, mism_d;
`endif

  logic                 start_edge;
  logic                 watched;
  logic                 px_req;
  logic                 px_ret;
  logic [COUNT_W-1:0]   outstanding;
  logic [TIMEOUT_W-1:0] wdog_inc;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      start_q    <= 1'b0;
      num_px_q   <= '0;
      seed_q     <= '0;
      golden_q   <= '0;
      issued_q   <= '0;
      returned_q <= '0;
      wdog_q     <= '0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      timeout_q  <= 1'b0;
`ifdef BIST_SIG_CAPTURE_EN
      sig_q      <= '0;
      mism_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      start_q    <= start_i;
      num_px_q   <= num_px_d;
      seed_q     <= seed_d;
      golden_q   <= golden_d;
      issued_q   <= issued_d;
      returned_q <= returned_d;
      wdog_q     <= wdog_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      timeout_q  <= timeout_d;
`ifdef BIST_SIG_CAPTURE_EN
      sig_q      <= sig_d;
      mism_q     <= mism_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    num_px_d   = num_px_q;
    seed_d     = seed_q;
    golden_d   = golden_q;
    issued_d   = issued_q;
    returned_d = returned_q;
    wdog_d     = '0;
    pass_d     = pass_q;
    fail_d     = fail_q;
    timeout_d  = timeout_q;
`ifdef BIST_SIG_CAPTURE_EN
    sig_d      = sig_q;
    mism_d     = mism_q;
`endif

    start_edge  = start_i & ~start_q;
    watched     = (state_q == RUN) || (state_q == DRAIN) || (state_q == SIGN);
    outstanding = issued_q - returned_q;
    wdog_inc    = wdog_q + TIMEOUT_W'(1);

    // Gate the request with abort so a discarded run never leaves a pixel in the core.
    px_req = (state_q == RUN) && (issued_q < num_px_q) && (outstanding < MaxOut) && !abort_i;
    // A return with nothing outstanding is spurious and dropped.
    px_ret = ((state_q == RUN) || (state_q == DRAIN)) && dp.px_done_i &&
             (returned_q != issued_q);

    if (px_req) issued_d = issued_q + COUNT_W'(1);
    if (px_ret) returned_d = returned_q + COUNT_W'(1);

    unique case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d    = SEED;
          num_px_d   = num_px_i;
          seed_d     = seed_i;
          golden_d   = golden_i;
          issued_d   = '0;
          returned_d = '0;
          timeout_d  = 1'b0;
          pass_d     = 1'b0;
          fail_d     = 1'b0;
`ifdef BIST_SIG_CAPTURE_EN
          sig_d      = '0;
          mism_d     = '0;
`endif
        end
      end
      SEED: begin
        if (num_px_q == '0) begin
          state_d = DONE;
          pass_d  = 1'b0;
          fail_d  = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (issued_d == num_px_q) state_d = DRAIN;
      end
      DRAIN: begin
        if (returned_d == num_px_q) state_d = SIGN;
      end
      SIGN: begin
        if (dp.sa_done_i) state_d = CHECK;
      end
      CHECK: begin
        state_d = DONE;
        pass_d  = (dp.sa_sig_i == golden_q);
        fail_d  = (dp.sa_sig_i != golden_q);
`ifdef BIST_SIG_CAPTURE_EN
        sig_d   = dp.sa_sig_i;
        mism_d  = dp.sa_sig_i ^ golden_q;
`endif
      end
      DONE: begin
        if (!start_i) begin
          state_d = IDLE;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Watchdog: any pixel activity or progress restarts the idle count.
    if (watched) begin
      if (px_req || dp.px_done_i || (state_d != state_q)) begin
        wdog_d = '0;
      end else begin
        wdog_d = wdog_inc;
        if (&wdog_inc) begin
          state_d   = DONE;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
          fail_d    = 1'b1;
        end
      end
    end

    if (abort_i) begin
      state_d    = IDLE;
      issued_d   = '0;
      returned_d = '0;
      wdog_d     = '0;
      pass_d     = 1'b0;
      fail_d     = 1'b0;
    end
  end

  assign dp.seed_load_o = (state_q == SEED);
  assign dp.seed_o      = seed_q;
  assign dp.lfsr_en_o   = watched;
  assign dp.px_req_o    = px_req;

  assign busy_o     = (state_q != IDLE) && (state_q != DONE);
  assign done_o     = (state_q == DONE);
  assign pass_o     = pass_q;
  assign fail_o     = fail_q;
  assign timeout_o  = timeout_q;
  assign px_count_o = returned_q;

`ifdef BIST_SIG_CAPTURE_EN
  assign sig_o      = sig_q;
  assign mismatch_o = mism_q;
`endif

endmodule

// File: tb/tb_bist_sequencer.sv
// Bench for bist_sequencer: behavioural core/SA responder plus per-run expectations from the run parameters.
module tb_bist_sequencer;
  localparam int DATA_W    = 24;
  localparam int COUNT_W   = 16;
  localparam int MAX_OUT   = 4;
  localparam int TIMEOUT_W = 10;
  localparam int BUDGET    = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset_i  = 1'b1;
  logic               start_i  = 1'b0;
  logic               abort_i  = 1'b0;
  logic [COUNT_W-1:0] num_px_i = '0;
  logic [DATA_W-1:0]  seed_i   = '0;
  logic [DATA_W-1:0]  golden_i = '0;
  logic               busy_o, done_o, pass_o, fail_o, timeout_o;
  logic [COUNT_W-1:0] px_count_o;
`ifdef BIST_SIG_CAPTURE_EN
  logic [DATA_W-1:0]  sig_o, mismatch_o;
`endif

  bist_sequencer_if #(.DATA_W(DATA_W)) dp ();

  bist_sequencer #(
    .DATA_W(DATA_W), .COUNT_W(COUNT_W), .MAX_OUTSTANDING(MAX_OUT), .TIMEOUT_W(TIMEOUT_W)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .abort_i(abort_i),
    .num_px_i(num_px_i), .seed_i(seed_i), .golden_i(golden_i),
    .dp(dp),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .fail_o(fail_o),
    .timeout_o(timeout_o), .px_count_o(px_count_o)
`ifdef BIST_SIG_CAPTURE_EN
    , .sig_o(sig_o), .mismatch_o(mismatch_o)
`endif
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Run configuration, written only by the main sequence.
  int                run_id    = 0;
  int                cfg_n     = 0;
  int                cfg_delay = 1;
  int                cfg_limit = 0;
  bit                cfg_sa    = 1'b0;
  logic [DATA_W-1:0] cfg_sig   = '0;

  // Observations, written only by the responder/monitor.
  int                mon_run        = 0;
  int                run_req        = 0;
  int                run_ret        = 0;
  int                run_seed_loads = 0;
  int                run_lfsr       = 0;
  int                max_out        = 0;
  int                done_cyc       = -1;
  int                last_ret_cyc   = -1;
  bit                sa_fired       = 1'b0;
  logic [DATA_W-1:0] seen_seed      = '0;
  int                due_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Core and signature-analyzer stand-in: returns each request cfg_delay cycles later,
  // stops after cfg_limit returns, then reports the signature once all pixels are back.
  initial begin
    dp.px_done_i = 1'b0;
    dp.sa_done_i = 1'b0;
    dp.sa_sig_i  = '0;
    forever begin
      @(negedge clk);
      if (mon_run != run_id) begin
        mon_run        = run_id;
        due_q.delete();
        run_req        = 0;
        run_ret        = 0;
        run_seed_loads = 0;
        run_lfsr       = 0;
        max_out        = 0;
        done_cyc       = -1;
        last_ret_cyc   = -1;
        sa_fired       = 1'b0;
        seen_seed      = '0;
      end
      if (dp.seed_load_o) begin
        run_seed_loads++;
        seen_seed = dp.seed_o;
      end
      if (dp.lfsr_en_o) run_lfsr++;
      if (dp.px_req_o) begin
        run_req++;
        due_q.push_back(cyc + cfg_delay);
      end
      if (done_o && done_cyc < 0) done_cyc = cyc;
      dp.px_done_i = 1'b0;
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
        void'(due_q.pop_front());
        if (run_ret < cfg_limit) begin
          dp.px_done_i = 1'b1;
          run_ret++;
          last_ret_cyc = cyc;
        end
      end
      if (run_req - run_ret > max_out) max_out = run_req - run_ret;
      dp.sa_done_i = 1'b0;
      if (cfg_sa && !sa_fired && cfg_n != 0 && run_ret == cfg_n && !dp.px_done_i) begin
        dp.sa_done_i = 1'b1;
        sa_fired     = 1'b1;
      end
      dp.sa_sig_i = cfg_sig;
    end
  end

  task automatic configure(input int n, input int delay, input int lim,
                           input logic [DATA_W-1:0] seed, input logic [DATA_W-1:0] golden,
                           input logic [DATA_W-1:0] sig, input bit sa_on);
    start_i = 1'b0;
    tick();
    num_px_i  = COUNT_W'(n);
    seed_i    = seed;
    golden_i  = golden;
    cfg_n     = n;
    cfg_delay = delay;
    cfg_limit = lim;
    cfg_sig   = sig;
    cfg_sa    = sa_on;
    run_id++;
    tick();
    start_i = 1'b1;
  endtask

  task automatic run_bist(input string name, input int n, input int delay, input int lim,
                          input logic [DATA_W-1:0] seed, input logic [DATA_W-1:0] golden,
                          input logic [DATA_W-1:0] sig);
    int w;
    int exp_ret;
    int exp_req;
    bit exp_to;
    bit exp_pass;
    exp_ret  = (lim < n) ? lim : n;
    exp_req  = (lim + MAX_OUT < n) ? lim + MAX_OUT : n;
    exp_to   = (n != 0) && (lim < n);
    exp_pass = (n != 0) && !exp_to && (sig == golden);

    configure(n, delay, lim, seed, golden, sig, 1'b1);
    tick();
    check_eq({name, ":busy_at_seed"}, 32'(busy_o), 1);
    check_eq({name, ":timeout_cleared_on_start"}, 32'(timeout_o), 0);
    w = 0;
    while (!done_o && w < BUDGET) begin
      tick();
      w++;
    end
    check_eq({name, ":done_reached"}, 32'(done_o), 1);
    @(negedge clk);
    #1;
    check_eq({name, ":seed_loads"}, run_seed_loads, 1);
    check_eq({name, ":seed_value"}, 32'(seen_seed), 32'(seed));
    check_eq({name, ":requests"}, run_req, exp_req);
    check_eq({name, ":px_count"}, 32'(px_count_o), exp_ret);
    check_eq({name, ":pass"}, 32'(pass_o), 32'(exp_pass));
    check_eq({name, ":fail"}, 32'(fail_o), 32'(!exp_pass));
    check_eq({name, ":timeout"}, 32'(timeout_o), 32'(exp_to));
    check_eq({name, ":busy_in_done"}, 32'(busy_o), 0);
    check_eq({name, ":lfsr_en_seen"}, 32'(run_lfsr != 0), 32'(n != 0));
    check_eq({name, ":outstanding_le_max"}, 32'(max_out <= MAX_OUT), 1);
    // The last return is sampled one edge after it is driven, then 2**W-1 idle cycles elapse.
    if (exp_to)
      check_eq({name, ":timeout_latency"}, done_cyc - last_ret_cyc, (1 << TIMEOUT_W));

    repeat ($urandom_range(1, 4)) begin
      tick();
      check_eq({name, ":done_held"}, 32'(done_o), 1);
      check_eq({name, ":pass_held"}, 32'(pass_o), 32'(exp_pass));
    end
    start_i = 1'b0;
    tick();
    check_eq({name, ":idle_done"}, 32'(done_o), 0);
    check_eq({name, ":idle_pass_fail"}, {30'd0, pass_o, fail_o}, 0);
    check_eq({name, ":idle_timeout_sticky"}, 32'(timeout_o), 32'(exp_to));
  endtask

  int                w;
  int                rn;
  int                rd;
  bit                rm;
  logic [DATA_W-1:0] rg;
  logic [DATA_W-1:0] rs;

  initial begin
    reset_i = 1'b1;
    repeat (2) tick();
    check_eq("reset:status", {27'd0, busy_o, done_o, pass_o, fail_o, timeout_o}, 0);
    check_eq("reset:strobes", {29'd0, dp.seed_load_o, dp.lfsr_en_o, dp.px_req_o}, 0);
    check_eq("reset:px_count", 32'(px_count_o), 0);
    reset_i = 1'b0;
    tick();

    run_bist("basic", 16, 2, 16, 24'h00ACE1, 24'h5A5A5A, 24'h5A5A5A);

    rg = DATA_W'($urandom);
    run_bist("slow_core", 8, 20, 8, DATA_W'($urandom), rg, rg);
    check_eq("slow_core:max_outstanding", max_out, MAX_OUT);

    run_bist("bad_sig", 4, 2, 4, DATA_W'($urandom), 24'h000000, 24'h000001);
`ifdef BIST_SIG_CAPTURE_EN
    check_eq("bad_sig:sig_o", 32'(sig_o), 32'h000001);
    check_eq("bad_sig:mismatch_o", 32'(mismatch_o), 32'h000001);
`endif

    rg = DATA_W'($urandom);
    run_bist("timeout", 5, 2, 3, DATA_W'($urandom), rg, rg);

    run_bist("zero_px", 0, 2, 0, DATA_W'($urandom), rg, rg);

    // Abort after the third request of a stalled run.
    configure(16, 20, 16, 24'h123456, 24'h0F0F0F, 24'h0F0F0F, 1'b1);
    w = 0;
    while (run_req < 3 && w < BUDGET) begin
      tick();
      w++;
    end
    check_eq("abort:three_requests_seen", 32'(run_req >= 3), 1);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check_eq("abort:requests", run_req, 3);
    check_eq("abort:idle_status", {28'd0, busy_o, done_o, pass_o, fail_o}, 0);
    check_eq("abort:idle_strobes", {30'd0, dp.lfsr_en_o, dp.px_req_o}, 0);
    check_eq("abort:px_count", 32'(px_count_o), 0);

    rg = DATA_W'($urandom);
    run_bist("after_abort", 6, 3, 6, DATA_W'($urandom), rg, rg);

    for (int i = 0; i < 6; i++) begin
      rn = $urandom_range(1, 12);
      rd = $urandom_range(1, 8);
      rm = 1'($urandom_range(0, 1));
      rg = DATA_W'($urandom);
      rs = rm ? rg : (rg ^ (24'h1 << $urandom_range(0, 23)));
      run_bist("rand", rn, rd, rn, DATA_W'($urandom), rg, rs);
    end

    // Reset while waiting for the signature analyzer.
    configure(2, 2, 2, 24'hABCDEF, 24'h111111, 24'h111111, 1'b0);
    w = 0;
    while (px_count_o != 2 && w < BUDGET) begin
      tick();
      w++;
    end
    tick();
    tick();
    check_eq("sign:waiting", {30'd0, busy_o, dp.lfsr_en_o}, 32'h3);
    reset_i = 1'b1;
    start_i = 1'b0;
    tick();
    check_eq("reset_sign:status", {27'd0, busy_o, done_o, pass_o, fail_o, timeout_o}, 0);
    check_eq("reset_sign:strobes", {29'd0, dp.seed_load_o, dp.lfsr_en_o, dp.px_req_o}, 0);
    check_eq("reset_sign:px_count", 32'(px_count_o), 0);
    check_eq("reset_sign:seed_o", 32'(dp.seed_o), 0);
    reset_i = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bist_sequencer.md
Name: bist_sequencer

Overview:
- Self-test controller for the pixel datapath: sequences LFSR seed load, pattern generation, gray/sobel processing and signature capture, then compares the signature against a golden value.
- Sits beside the LFSR, gray/sobel core and signature analyzer. It drives their enables and request strobes, and reports pass/fail/timeout to the top level.
- Limits in-flight pixels so the core is never overrun.

Parameters:
- DATA_W, 24, pixel/seed/signature width.
- COUNT_W, 16, width of the pixel counters.
- MAX_OUTSTANDING, 4, maximum issued-but-unreturned pixels (power of two, 1..8).
- TIMEOUT_W, 10, width of the stall watchdog; timeout fires after 2**TIMEOUT_W-1 idle cycles.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- start_i  in  1  level; a rising edge while IDLE starts a run.
- abort_i  in  1  synchronous abort; highest priority after reset.
- num_px_i  in  COUNT_W  pixels per run; latched at start.
- seed_i  in  DATA_W  LFSR seed; latched at start.
- golden_i  in  DATA_W  expected signature; latched at start.
- seed_load_o  out  1  one-cycle seed-load strobe to the LFSR.
- seed_o  out  DATA_W  latched seed; valid while seed_load_o=1.
- lfsr_en_o  out  1  LFSR/SA run enable.
- px_req_o  out  1  one-cycle request for the next LFSR pixel.
- px_done_i  in  1  core output pixel ready; one pulse per pixel.
- sa_done_i  in  1  signature analyzer finished.
- sa_sig_i  in  DATA_W  signature value.
- busy_o  out  1  high in every state except IDLE and DONE.
- done_o  out  1  high in DONE.
- pass_o  out  1  valid while done_o=1.
- fail_o  out  1  valid while done_o=1.
- timeout_o  out  1  sticky until next start or reset.
- px_count_o  out  COUNT_W  pixels returned in the current run.

Behaviour:
- Reset (reset_i=1 at a clock edge): state=IDLE; all outputs 0; counters, latches and the start edge detector cleared.
- States: IDLE, SEED, RUN, DRAIN, SIGN, CHECK, DONE.
- IDLE → SEED on a start_i rising edge (start_i registered; edge = start_i & ~start_q). On that edge, latch num_px_i, seed_i and golden_i, and clear counters and timeout_o.
- SEED: seed_load_o=1 for exactly one cycle.
  - If latched num_px=0 → DONE with fail_o=1, pass_o=0 (invalid config).
  - Otherwise → RUN.
- RUN: lfsr_en_o=1.
  - px_req_o=1 when issued<num_px and (issued-returned)<MAX_OUTSTANDING. Issued increments on px_req_o.
  - Returned increments on px_done_i. px_done_i and px_req_o in the same cycle update both counters.
  - When issued reaches num_px → DRAIN.
- DRAIN: lfsr_en_o=1, no requests. When returned=num_px → SIGN.
- SIGN: lfsr_en_o=1; wait for sa_done_i → CHECK.
- CHECK: one cycle; lfsr_en_o=0. Register pass = (sa_sig_i==golden), fail = ~pass → DONE.
- DONE: done_o=1; pass_o/fail_o held. Stays until start_i is low, then → IDLE. A new run requires a fresh rising edge. pass_o/fail_o return to 0 in IDLE.
- px_done_i outside RUN/DRAIN: ignored, not counted.
- px_done_i when returned=issued (spurious) in RUN/DRAIN: ignored.
- Watchdog (RUN, DRAIN, SIGN only):
  - Counter clears on px_req_o, px_done_i or a state change; otherwise increments.
  - At all-ones → DONE with timeout_o=1, fail_o=1, pass_o=0.
- abort_i=1 in any state → IDLE next cycle, all strobes and enables 0. Status outputs clear; timeout_o is kept.
- Counters do not wrap: issued saturates at num_px; px_count_o=returned.
- Minimum latency, start edge to done_o: N=1 with 1-cycle core/SA response is about 6 cycles.

Optional Feature:
- Macro: BIST_SIG_CAPTURE_EN.
- When defined, adds output sig_o [DATA_W] and output mismatch_o [DATA_W]:
  - sig_o = sa_sig_i registered in CHECK.
  - mismatch_o = sig_o ^ golden.
  - Both hold until the next start, clear on reset.
- When undefined, neither port exists and no capture register is built. Pass/fail behaviour is identical either way.

Test Plan:
- num_px=16, seed=24'h00ACE1, core returns each pixel 2 cycles after px_req_o, sa_sig_i=golden=24'h5A5A5A at sa_done_i:
  - expect seed_load_o exactly once, 16 px_req_o pulses, px_count_o=16, pass_o=1, fail_o=0, done_o held until start_i falls.
- num_px=8, core delays returns by 20 cycles:
  - expect issued-returned never above 4, px_req_o stalls after 4, all 8 complete, pass_o=1 with matching signature.
- num_px=4, sa_sig_i=24'h000001, golden=24'h000000:
  - expect fail_o=1, pass_o=0.
  - With BIST_SIG_CAPTURE_EN: mismatch_o=24'h000001.
- num_px=5, core returns only 3 pixels:
  - expect timeout_o=1, fail_o=1 exactly 1023 cycles after the last return.
  - timeout_o stays high in IDLE and clears on the next start.
- num_px=0:
  - expect done_o=1, fail_o=1, no px_req_o, no lfsr_en_o.
- abort_i mid-RUN after 3 requests:
  - expect IDLE next cycle, px_req_o/lfsr_en_o=0.
  - A new start_i edge runs cleanly with counters restarting at 0.
  - reset_i mid-SIGN: all outputs 0 next cycle.
